des_key_scheduler: RTL

DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

---
 rtl/des_key_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/des_key_scheduler.sv
// DES round-key generator: schedules NKEYS 64-bit keys into 16x48-bit round-key
// storage, one round per falling CLK edge, with a registered random-access read port.
//
// state | meaning
// IDLE  | waiting for GENERATE; stored keys retained and readable
// RUN   | one round key produced per edge, key by key
// DONE  | all keys valid; held while GENERATE stays high
module des_key_scheduler #(
   parameter int NKEYS = 1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [0:64*NKEYS-1]    UK,
   input  logic                   GENERATE,
   input  logic                   DECRYPT,
   input  logic [1:0]             RD_KEY,
   input  logic [3:0]             RD_ROUND,
   output logic [47:0]            RK_OUT,
   output logic                   BUSY,
   output logic                   GENERATED
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [1:0] K_LAST = 2'(NKEYS - 1);

   localparam int PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Vectors are [msb:0] with DES bit 1 at the msb, so DES bit i sits at index width-i.
   function automatic logic [55:0] pc1(input logic [63:0] key);
      logic [55:0] o;
      o = '0;
      for (int j = 0; j < 56; j++) begin
         o[55-j] = key[64-PC1_TAB[j]];
      end
      return o;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] o;
      o = '0;
      for (int j = 0; j < 48; j++) begin
         o[47-j] = cd[56-PC2_TAB[j]];
      end
      return o;
   endfunction

   function automatic logic [55:0] rotl(input logic [55:0] cd, input logic two);
      logic [27:0] c;
      logic [27:0] d;
      c = cd[55:28];
      d = cd[27:0];
      if (two) begin
         c = {c[25:0], c[27:26]};
         d = {d[25:0], d[27:26]};
      end else begin
         c = {c[26:0], c[27]};
         d = {d[26:0], d[27]};
      end
      return {c, d};
   endfunction

   logic [1:0]            state;
   logic [55:0]           cd;
   logic [3:0]            r;
   logic [1:0]            k;
   logic                  dec_q;
   logic [0:64*NKEYS-1]   uk_q;
   logic [47:0]           store [NKEYS][16];

   logic                  two;
   logic [55:0]           cd_rot;
   logic [47:0]           rk_new;
   logic [63:0]           key0;
   logic [63:0]           key_next;
   int                    kn;
   logic [3:0]            p;
   logic [47:0]           rd_data;

   always_comb begin
      two      = !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
      cd_rot   = rotl(cd, two);
      rk_new   = pc2(cd_rot);
      key0     = UK[0 +: 64];
      kn       = (k < K_LAST) ? int'(k) + 1 : int'(k);
      key_next = uk_q[64*kn +: 64];
   end

   // Keys beyond NKEYS read as zero because no storage row matches.
   always_comb begin
      p       = dec_q ? (4'd15 - RD_ROUND) : RD_ROUND;
      rd_data = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (RD_KEY == 2'(i)) begin
            rd_data = store[i][p];
         end
      end
   end

   always_ff @(negedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         cd        <= '0;
         r         <= '0;
         k         <= '0;
         dec_q     <= 1'b0;
         uk_q      <= '0;
         BUSY      <= 1'b0;
         GENERATED <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (GENERATE) begin
                  uk_q  <= UK;
                  dec_q <= DECRYPT;
                  cd    <= pc1(key0);
                  r     <= '0;
                  k     <= '0;
                  BUSY  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               if (r == 4'd15) begin
                  if (k < K_LAST) begin
                     cd <= pc1(key_next);
                     k  <= k + 2'd1;
                     r  <= '0;
                  end else begin
                     cd        <= cd_rot;
                     BUSY      <= 1'b0;
                     GENERATED <= 1'b1;
                     state     <= DONE;
                  end
               end else begin
                  cd <= cd_rot;
                  r  <= r + 4'd1;
               end
            end
            DONE: begin
               if (!GENERATE) begin
                  GENERATED <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(negedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NKEYS; i++) begin
            for (int j = 0; j < 16; j++) begin
               store[i][j] <= '0;
            end
         end
      end else if (state == RUN) begin
         for (int i = 0; i < NKEYS; i++) begin
            for (int j = 0; j < 16; j++) begin
               if (k == 2'(i) && r == 4'(j)) begin
                  store[i][j] <= rk_new;
               end
            end
         end
      end
   end

   always_ff @(negedge CLK or negedge RST) begin
      if (!RST) begin
         RK_OUT <= '0;
      end else begin
         RK_OUT <= rd_data;
      end
   end

endmodule
